// File: rtl/refill_pkg.sv
// refill_pkg: state encoding and default widths shared by the refill line buffer files.
package refill_pkg;
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
   localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/refill_line_buffer_if.sv
// refill_line_buffer_if: bundle of the refill request, AXI R beat and line/fetch result signals.
interface refill_line_buffer_if
   import refill_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int LINE_WORDS  = 4,
   parameter int FETCH_WORDS = 2
) ();
   logic                            start;
   logic [$clog2(LINE_WORDS)-1:0]   offset;
   logic                            uncached;
   logic                            rvalid;
   logic                            rlast;
   logic [DATA_W-1:0]               rdata;
   logic                            consume;
   logic                            rready;
   logic                            busy;
   logic                            line_valid;
   logic [LINE_WORDS*DATA_W-1:0]    line_data;
   logic [FETCH_WORDS*DATA_W-1:0]   fetch_data;
   logic [FETCH_WORDS-1:0]          fetch_mask;
   logic                            fetch_valid;
   logic                            err;
   modport master (
      output start, offset, uncached, rvalid, rlast, rdata, consume,
      input  rready, busy, line_valid, line_data, fetch_data, fetch_mask, fetch_valid, err
   );
   modport slave (
      input  start, offset, uncached, rvalid, rlast, rdata, consume,
      output rready, busy, line_valid, line_data, fetch_data, fetch_mask, fetch_valid, err
   );
endinterface

// File: rtl/fetch_window_mux.sv
// fetch_window_mux: selects the fetch window from a line; cached windows stop at the line end, uncached uses word 0 only.
module fetch_window_mux
   import refill_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int LINE_WORDS  = 4,
   parameter int FETCH_WORDS = 2
) (
   input  logic [$clog2(LINE_WORDS)-1:0]  offset,
   input  logic                           uncached,
   input  logic [LINE_WORDS*DATA_W-1:0]   line,
   output logic [FETCH_WORDS*DATA_W-1:0]  fetch_data,
   output logic [FETCH_WORDS-1:0]         fetch_mask
);
   localparam int OW = $clog2(LINE_WORDS);
   logic [DATA_W-1:0] words [LINE_WORDS];
   for (genvar k = 0; k < LINE_WORDS; k++) begin : g_word
      assign words[k] = line[k*DATA_W +: DATA_W];
   end
   for (genvar i = 0; i < FETCH_WORDS; i++) begin : g_win
      logic [OW:0] pos;
      assign pos = uncached ? '0 : {1'b0, offset} + (OW+1)'(i);
      assign fetch_mask[i] = uncached ? (i == 0) : (pos < (OW+1)'(LINE_WORDS));
      assign fetch_data[i*DATA_W +: DATA_W] = fetch_mask[i] ? words[pos[OW-1:0]] : '0;
   end
endmodule

// File: rtl/refill_line_buffer.sv
// refill_line_buffer: collects an AXI read burst into a cache line and presents the requested fetch window.
// Optional macro REFILL_EARLY_FWD_EN raises fetch_valid as soon as the window's words have arrived.
module refill_line_buffer
   import refill_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int LINE_WORDS  = 4,
   parameter int FETCH_WORDS = 2
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   input  logic [$clog2(LINE_WORDS)-1:0]  offset,
   input  logic                           uncached,
   input  logic                           rvalid,
   input  logic                           rlast,
   input  logic [DATA_W-1:0]              rdata,
   input  logic                           consume,
   output logic                           rready,
   output logic                           busy,
   output logic                           line_valid,
   output logic [LINE_WORDS*DATA_W-1:0]   line_data,
   output logic [FETCH_WORDS*DATA_W-1:0]  fetch_data,
   output logic [FETCH_WORDS-1:0]         fetch_mask,
   output logic                           fetch_valid,
   output logic                           err
);
   localparam int OW = $clog2(LINE_WORDS);
   state_t state, nxt;
   logic [OW:0] beat_cnt;
   logic [OW-1:0] off_q;
   logic unc_q;
   logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;
   logic [FETCH_WORDS-1:0] win_mask;
   logic acc, start_ok, drop, short_burst;
   assign rready      = state == FILL;
   assign busy        = state != IDLE;
   assign line_valid  = state == DONE;
   assign line_data   = line_q;
   assign acc         = rvalid && rready;
   assign start_ok    = start && state != FILL;
   assign drop        = unc_q ? beat_cnt != '0 : beat_cnt == (OW+1)'(LINE_WORDS);
   assign short_burst = !unc_q && beat_cnt < (OW+1)'(LINE_WORDS-1);
   assign fetch_mask  = win_mask & {FETCH_WORDS{busy}};
   always_comb begin
      nxt = state;
      if (state == FILL)
         nxt = (acc && rlast) ? DONE : FILL;
      else
         nxt = start ? FILL : (state == DONE && consume) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         beat_cnt <= '0;
         off_q    <= '0;
         unc_q    <= 1'b0;
         err      <= 1'b0;
         line_q   <= '0;
      end else begin
         state <= nxt;
         if (start_ok) begin
            beat_cnt <= '0;
            off_q    <= offset;
            unc_q    <= uncached;
            err      <= 1'b0;
         end else if (acc) begin
            if (drop) begin
               err <= 1'b1;
            end else begin
               line_q[beat_cnt[OW-1:0]] <= rdata;
               beat_cnt <= beat_cnt + 1'b1;
            end
            if (rlast && short_burst) err <= 1'b1;
         end
      end
   end
   fetch_window_mux #(
      .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .FETCH_WORDS(FETCH_WORDS)
   ) u_mux (
      .offset(off_q), .uncached(unc_q), .line(line_q),
      .fetch_data(fetch_data), .fetch_mask(win_mask)
   );
`ifdef REFILL_EARLY_FWD_EN
   // Track which line words hold data from the current burst, so the window can be forwarded early.
   logic [LINE_WORDS-1:0] wr_mask, req_mask;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         wr_mask <= '0;
      else if (start_ok)
         wr_mask <= '0;
      else if (acc && !drop)
         wr_mask[beat_cnt[OW-1:0]] <= 1'b1;
   end
   always_comb begin
      req_mask = '0;
      for (int k = 0; k < LINE_WORDS; k++)
         req_mask[k] = unc_q ? (k == 0) : (k >= int'(off_q) && k < int'(off_q) + FETCH_WORDS);
   end
   assign fetch_valid = line_valid || (state == FILL && &(wr_mask | ~req_mask));
`else
   assign fetch_valid = line_valid;
`endif
endmodule

// File: tb/tb_refill_line_buffer.sv
// tb_refill_line_buffer: table-driven refill vectors plus hand sequences for priority, early forwarding and reset.
module tb_refill_line_buffer;
   localparam int DW = 32, LW = 4, FW = 2;
`ifdef REFILL_EARLY_FWD_EN
   localparam logic EARLY = 1'b1;
`else
   localparam logic EARLY = 1'b0;
`endif
   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;
   refill_line_buffer_if #(.DATA_W(DW), .LINE_WORDS(LW), .FETCH_WORDS(FW)) bus ();
   refill_line_buffer #(.DATA_W(DW), .LINE_WORDS(LW), .FETCH_WORDS(FW)) dut (
      .clk(clk), .rstn(rstn), .start(bus.start), .offset(bus.offset), .uncached(bus.uncached),
      .rvalid(bus.rvalid), .rlast(bus.rlast), .rdata(bus.rdata), .consume(bus.consume),
      .rready(bus.rready), .busy(bus.busy), .line_valid(bus.line_valid), .line_data(bus.line_data),
      .fetch_data(bus.fetch_data), .fetch_mask(bus.fetch_mask), .fetch_valid(bus.fetch_valid), .err(bus.err)
   );
   typedef struct {
      logic [1:0]        off;
      logic              unc;
      int                n;
      logic [4:0][31:0]  beats;
      logic [127:0]      line;
      logic [63:0]       fd;
      logic [1:0]        fm;
      logic              err;
   } vec_t;
   vec_t tab[9];
   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic begin_fill(input logic [1:0] off, input logic unc);
      bus.start = 1'b1; bus.offset = off; bus.uncached = unc;
      step();
      bus.start = 1'b0;
   endtask
   task automatic beat(input logic [31:0] d, input logic last);
      bus.rvalid = 1'b1; bus.rdata = d; bus.rlast = last;
      step();
      bus.rvalid = 1'b0; bus.rlast = 1'b0;
   endtask
   task automatic run_vec(input vec_t v, input int id);
      begin_fill(v.off, v.unc);
      chk($sformatf("v%0d_rready_fill", id), 128'(bus.rready), 128'(1));
      chk($sformatf("v%0d_fvalid_start", id), 128'(bus.fetch_valid), 128'(0));
      for (int b = 0; b < v.n - 1; b++) beat(v.beats[b], 1'b0);
      chk($sformatf("v%0d_lvalid_pre", id), 128'(bus.line_valid), 128'(0));
      beat(v.beats[v.n-1], 1'b1);
      chk($sformatf("v%0d_lvalid", id), 128'(bus.line_valid), 128'(1));
      chk($sformatf("v%0d_rready_done", id), 128'(bus.rready), 128'(0));
      chk($sformatf("v%0d_line", id), bus.line_data, v.line);
      chk($sformatf("v%0d_fdata", id), 128'(bus.fetch_data), 128'(v.fd));
      chk($sformatf("v%0d_fmask", id), 128'(bus.fetch_mask), 128'(v.fm));
      chk($sformatf("v%0d_err", id), 128'(bus.err), 128'(v.err));
      chk($sformatf("v%0d_fvalid", id), 128'(bus.fetch_valid), 128'(1));
      beat(32'hFFFF_FFFF, 1'b1);
      chk($sformatf("v%0d_line_stable", id), bus.line_data, v.line);
      chk($sformatf("v%0d_err_stable", id), 128'(bus.err), 128'(v.err));
      bus.consume = 1'b1;
      step();
      bus.consume = 1'b0;
      chk($sformatf("v%0d_busy_idle", id), 128'(bus.busy), 128'(0));
   endtask
   initial begin
      tab[0] = '{off:2'd1, unc:1'b0, n:4, beats:{32'h0, 32'h44, 32'h33, 32'h22, 32'h11},
                 line:128'h00000044_00000033_00000022_00000011, fd:{32'h33, 32'h22}, fm:2'b11, err:1'b0};
      tab[1] = '{off:2'd3, unc:1'b0, n:4, beats:{32'h0, 32'h44, 32'h33, 32'h22, 32'h11},
                 line:128'h00000044_00000033_00000022_00000011, fd:{32'h0, 32'h44}, fm:2'b01, err:1'b0};
      tab[2] = '{off:2'd0, unc:1'b0, n:4, beats:{32'h0, 32'h44, 32'h33, 32'h22, 32'h11},
                 line:128'h00000044_00000033_00000022_00000011, fd:{32'h22, 32'h11}, fm:2'b11, err:1'b0};
      tab[3] = '{off:2'd2, unc:1'b0, n:4, beats:{32'h0, 32'h44, 32'h33, 32'h22, 32'h11},
                 line:128'h00000044_00000033_00000022_00000011, fd:{32'h44, 32'h33}, fm:2'b11, err:1'b0};
      tab[4] = '{off:2'd2, unc:1'b1, n:1, beats:{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                 line:128'h00000044_00000033_00000022_DEADBEEF, fd:{32'h0, 32'hDEADBEEF}, fm:2'b01, err:1'b0};
      tab[5] = '{off:2'd0, unc:1'b1, n:2, beats:{32'h0, 32'h0, 32'h0, 32'hAAAA0002, 32'hAAAA0001},
                 line:128'h00000044_00000033_00000022_AAAA0001, fd:{32'h0, 32'hAAAA0001}, fm:2'b01, err:1'b1};
      tab[6] = '{off:2'd0, unc:1'b0, n:2, beats:{32'h0, 32'h0, 32'h0, 32'h66, 32'h55},
                 line:128'h00000044_00000033_00000066_00000055, fd:{32'h66, 32'h55}, fm:2'b11, err:1'b1};
      tab[7] = '{off:2'd1, unc:1'b0, n:5, beats:{32'h99, 32'h44, 32'h33, 32'h22, 32'h11},
                 line:128'h00000044_00000033_00000022_00000011, fd:{32'h33, 32'h22}, fm:2'b11, err:1'b1};
      tab[8] = '{off:2'd3, unc:1'b0, n:4, beats:{32'h0, 32'h44, 32'h33, 32'h22, 32'h11},
                 line:128'h00000044_00000033_00000022_00000011, fd:{32'h0, 32'h44}, fm:2'b01, err:1'b0};
      bus.start = 0; bus.offset = 0; bus.uncached = 0; bus.rvalid = 0;
      bus.rlast = 0; bus.rdata = 0; bus.consume = 0;
      step();
      step();
      chk("rst_rready", 128'(bus.rready), 128'(0));
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_lvalid", 128'(bus.line_valid), 128'(0));
      chk("rst_line", bus.line_data, 128'(0));
      chk("rst_fmask", 128'(bus.fetch_mask), 128'(0));
      chk("rst_fvalid", 128'(bus.fetch_valid), 128'(0));
      chk("rst_err", 128'(bus.err), 128'(0));
      @(negedge clk) rstn = 1'b1;
      step();
      for (int v = 0; v < 9; v++) run_vec(tab[v], v);
      // start with consume in DONE refills at once; a start during FILL is ignored
      begin_fill(2'd0, 1'b0);
      beat(32'h11, 1'b0); beat(32'h22, 1'b0); beat(32'h33, 1'b0); beat(32'h44, 1'b1);
      bus.start = 1'b1; bus.consume = 1'b1; bus.offset = 2'd0;
      step();
      bus.start = 1'b0; bus.consume = 1'b0;
      chk("prio_busy", 128'(bus.busy), 128'(1));
      chk("prio_rready", 128'(bus.rready), 128'(1));
      chk("prio_lvalid", 128'(bus.line_valid), 128'(0));
      beat(32'h11, 1'b0);
      chk("fwd_beat0", 128'(bus.fetch_valid), 128'(0));
      beat(32'h22, 1'b0);
      chk("fwd_beat1", 128'(bus.fetch_valid), 128'(EARLY));
      chk("fwd_data", 128'(bus.fetch_data), 128'({32'h22, 32'h11}));
      bus.start = 1'b1; bus.offset = 2'd3;
      step();
      bus.start = 1'b0;
      chk("ign_busy", 128'(bus.busy), 128'(1));
      chk("ign_fvalid", 128'(bus.fetch_valid), 128'(EARLY));
      beat(32'h33, 1'b0); beat(32'h44, 1'b1);
      chk("ign_line", bus.line_data, 128'h00000044_00000033_00000022_00000011);
      chk("ign_fdata", 128'(bus.fetch_data), 128'({32'h22, 32'h11}));
      chk("ign_fmask", 128'(bus.fetch_mask), 128'(2'b11));
      chk("ign_err", 128'(bus.err), 128'(0));
      bus.consume = 1'b1;
      step();
      bus.consume = 1'b0;
      // asynchronous reset in the middle of a burst
      begin_fill(2'd0, 1'b0);
      beat(32'h11, 1'b0); beat(32'h22, 1'b0);
      #2 rstn = 1'b0;
      #1;
      chk("arst_rready", 128'(bus.rready), 128'(0));
      chk("arst_busy", 128'(bus.busy), 128'(0));
      chk("arst_lvalid", 128'(bus.line_valid), 128'(0));
      chk("arst_line", bus.line_data, 128'(0));
      chk("arst_fmask", 128'(bus.fetch_mask), 128'(0));
      chk("arst_fvalid", 128'(bus.fetch_valid), 128'(0));
      @(negedge clk) rstn = 1'b1;
      step();
      run_vec(tab[2], 20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
